// File: rtl/pair_sum_pkg.sv
// Shared state encoding and default sizing for the pair-sum memory walker.
// Pure declarations; no logic, no latency, no flow control.
package pair_sum_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        EMIT,
        DONE
    } state_e;

endpackage

// File: rtl/pair_sum_sequencer_if.sv
// Control, memory-read and result bundle for the pair-sum walker.
// master = walker side, slave = environment (memory, consumer, controller).
interface pair_sum_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);

    logic              start;
    logic              abort;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   out_sum;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;

    modport master (
        input  start, abort, mem_rd_data, out_ready,
        output mem_rd_en, mem_addr, out_valid, out_sum, busy, done, count
    );

    modport slave (
        output start, abort, mem_rd_data, out_ready,
        input  mem_rd_en, mem_addr, out_valid, out_sum, busy, done, count
    );

endinterface

// File: rtl/pair_sum_sequencer.sv
// Walks an external memory, emitting mem[i]+mem[i-1] per word until a zero word or DEPTH.
// First result 3 cycles after start; each later one 3 cycles plus out_ready stall cycles.
module pair_sum_sequencer
    import pair_sum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    pair_sum_sequencer_if.master   bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W:0]   sum_q, sum_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            prev_q  <= '0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        count_d = count_q;
        sum_d   = sum_q;

        // abort wins over everything, including a same-cycle EMIT handshake
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        idx_d   = '0;
                        prev_d  = '0;
                        count_d = '0;
                        state_d = READ;
                    end
                end
                READ: state_d = WAIT;
                WAIT: begin
                    if (bus.mem_rd_data == '0) begin
                        state_d = DONE;
                    end else begin
                        sum_d   = {1'b0, prev_q} + {1'b0, bus.mem_rd_data};
                        prev_d  = bus.mem_rd_data;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        count_d = count_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = READ;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en = (state_q == READ);
    assign bus.mem_addr  = idx_q;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_sum   = sum_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.count     = count_q;

endmodule

// File: tb/tb_pair_sum_sequencer.sv
// Directed bench for pair_sum_sequencer: memory model, result monitor, one task per scenario.
module tb_pair_sum_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pair_sum_sequencer_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    pair_sum_sequencer #(.DATA_W(16), .ADDR_W(4), .DEPTH(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [16];
    logic [16:0] got [$];
    int          done_cnt = 0;
    logic        rd_prev = 1'b0;

    // Memory answers one cycle after the strobe; junk otherwise so mistimed sampling shows.
    always @(posedge clk) begin
        bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : 16'hDEAD;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready && !bus.abort) got.push_back(bus.out_sum);
            if (bus.done) done_cnt++;
            if (bus.mem_rd_en) begin
                checks++;
                if (rd_prev) begin
                    errors++;
                    $display("FAIL one_read_outstanding: mem_rd_en high two cycles in a row at %0t", $time);
                end
            end
            rd_prev <= bus.mem_rd_en;
        end
    end

    task automatic fill_mem(input logic [15:0] v0, input logic [15:0] v1,
                            input logic [15:0] v2, input logic [15:0] v3);
        for (int i = 0; i < 16; i++) mem[i] = 16'd99;
        mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3;
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        checks++;
        while (bus.busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, max_cycles);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.busy, bus.out_valid, bus.mem_rd_en, bus.done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/valid/rd_en/done=%b required 0000",
                     {bus.busy, bus.out_valid, bus.mem_rd_en, bus.done});
        end
        checks++;
        if (bus.count !== 5'd0 || bus.out_sum !== 17'd0) begin
            errors++;
            $display("FAIL reset_data: count=%0d out_sum=%0h required 0 and 0", bus.count, bus.out_sum);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_sentinel();
        logic [16:0] exp [3] = '{17'd3, 17'd8, 17'd12};
        int base = done_cnt;
        got.delete();
        fill_mem(16'd3, 16'd5, 16'd7, 16'd0);
        pulse_start();
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 4'd0) begin
            errors++;
            $display("FAIL sent_read0: rd_en=%b addr=%0d required 1 and 0", bus.mem_rd_en, bus.mem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sent_wait_valid: out_valid=%b required 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 17'd3) begin
            errors++;
            $display("FAIL sent_latency: out_valid=%b out_sum=%0d required 1 and 3", bus.out_valid, bus.out_sum);
        end
        wait_idle("sent", 100);
        repeat (5) @(negedge clk);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL sent_nresults: got %0d results required 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL sent_sum%0d: got %0d required %0d", i, got[i], exp[i]);
            end
        end
        checks++;
        if (bus.count !== 5'd3 || done_cnt - base != 1) begin
            errors++;
            $display("FAIL sent_end: count=%0d done_pulses=%0d required 3 and 1", bus.count, done_cnt - base);
        end
    endtask

    task automatic test_full_depth();
        int base = done_cnt;
        got.delete();
        for (int i = 0; i < 16; i++) mem[i] = 16'd99;
        for (int i = 0; i < 11; i++) mem[i] = 16'(i + 1);
        pulse_start();
        wait_idle("full", 200);
        checks++;
        if (got.size() != 11) begin
            errors++;
            $display("FAIL full_nresults: got %0d results required 11", got.size());
        end
        for (int i = 0; i < 11 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 17'(2 * i + 1)) begin
                errors++;
                $display("FAIL full_sum%0d: got %0d required %0d", i, got[i], 2 * i + 1);
            end
        end
        checks++;
        if (bus.count !== 5'd11 || done_cnt - base != 1) begin
            errors++;
            $display("FAIL full_end: count=%0d done_pulses=%0d required 11 and 1", bus.count, done_cnt - base);
        end
    endtask

    task automatic test_overflow();
        got.delete();
        fill_mem(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
        pulse_start();
        wait_idle("ovf", 100);
        checks++;
        if (got.size() != 2 || got[0] !== 17'h0FFFF || got[1] !== 17'h1FFFE) begin
            errors++;
            $display("FAIL ovf_sums: n=%0d first=%0h second=%0h required 2, ffff, 1fffe",
                     got.size(), got.size() > 0 ? got[0] : 17'h0, got.size() > 1 ? got[1] : 17'h0);
        end
        checks++;
        if (bus.count !== 5'd2) begin
            errors++;
            $display("FAIL ovf_count: count=%0d required 2", bus.count);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        got.delete();
        fill_mem(16'd3, 16'd5, 16'd0, 16'd0);
        bus.out_ready = 1'b0;
        pulse_start();
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 17'd3 || bus.count !== 5'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b sum=%0d count=%0d required 1, 3, 0",
                         k, bus.out_valid, bus.out_sum, bus.count);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.count !== 5'd1) begin
            errors++;
            $display("FAIL bp_release: count=%0d required 1", bus.count);
        end
        wait_idle("bp", 100);
        checks++;
        if (got.size() != 2 || got[0] !== 17'd3 || got[1] !== 17'd8 || bus.count !== 5'd2) begin
            errors++;
            $display("FAIL bp_results: n=%0d count=%0d required 2 results (3,8) and count 2",
                     got.size(), bus.count);
        end
    endtask

    task automatic test_abort();
        int base = done_cnt;
        int n = 0;
        got.delete();
        fill_mem(16'd3, 16'd5, 16'd7, 16'd0);
        pulse_start();
        while (got.size() < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if ({bus.busy, bus.out_valid, bus.mem_rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: busy/valid/rd_en=%b required 000",
                     {bus.busy, bus.out_valid, bus.mem_rd_en});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.count !== 5'd1 || got.size() != 1 || done_cnt != base) begin
            errors++;
            $display("FAIL abort_effect: count=%0d results=%0d done_pulses=%0d required 1, 1, 0",
                     bus.count, got.size(), done_cnt - base);
        end
    endtask

    task automatic test_start_ignored();
        got.delete();
        fill_mem(16'd3, 16'd5, 16'd7, 16'd0);
        pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        wait_idle("restart", 100);
        checks++;
        if (got.size() != 3 || got[2] !== 17'd12 || bus.count !== 5'd3) begin
            errors++;
            $display("FAIL restart_ignored: n=%0d count=%0d required 3 results ending 12, count 3",
                     got.size(), bus.count);
        end
    endtask

    task automatic test_rst_mid_walk();
        int base;
        got.delete();
        fill_mem(16'd3, 16'd5, 16'd7, 16'd0);
        pulse_start();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.out_valid, bus.mem_rd_en, bus.done} !== 4'b0000 ||
            bus.count !== 5'd0 || bus.out_sum !== 17'd0) begin
            errors++;
            $display("FAIL rst_mid: flags=%b count=%0d sum=%0d required 0000, 0, 0",
                     {bus.busy, bus.out_valid, bus.mem_rd_en, bus.done}, bus.count, bus.out_sum);
        end
        base = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt != base || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: done_pulses=%0d busy=%b required 0 and 0", done_cnt - base, bus.busy);
        end
        got.delete();
        pulse_start();
        wait_idle("rst_fresh", 100);
        checks++;
        if (got.size() != 3 || got[0] !== 17'd3 || got[1] !== 17'd8 || got[2] !== 17'd12 ||
            bus.count !== 5'd3 || done_cnt - base != 1) begin
            errors++;
            $display("FAIL rst_fresh_walk: n=%0d count=%0d done_pulses=%0d required 3 (3,8,12), 3, 1",
                     got.size(), bus.count, done_cnt - base);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 16'd0;
        test_reset();
        test_sentinel();
        test_full_depth();
        test_overflow();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_rst_mid_walk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
